// File: rtl/ram_banked_stream_if.sv
// ram_banked_stream_if: request, read-result and status bundle for ram_banked_stream
interface ram_banked_stream_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic              req_incr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              ptr_load;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] ptr;
   logic              busy;
   modport master (
      output req_valid, req_we, req_incr, req_addr, req_wdata, ptr_load,
      input  req_ready, rd_valid, rd_data, ptr, busy
   );
   modport slave (
      input  req_valid, req_we, req_incr, req_addr, req_wdata, ptr_load,
      output req_ready, rd_valid, rd_data, ptr, busy
   );
endinterface

// File: rtl/ram_banked_stream.sv
// ram_banked_stream: banked RAM behind one valid/ready port with streaming pointer and post-reset clear
module ram_banked_stream #(
   parameter int DATA_W         = 8,
   parameter int BANK_ADDR_W    = 3,
   parameter int BANK_SEL_W     = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic clk,
   input logic rst,
   ram_banked_stream_if.slave bus
);
   localparam int ADDR_W    = BANK_SEL_W + BANK_ADDR_W;
   localparam int NUM_BANKS = 1 << BANK_SEL_W;
   localparam int DEPTH     = 1 << BANK_ADDR_W;
   typedef enum logic {CLEAR, READY} state_t;
   state_t                 state_q;
   logic                   busy_q;
   logic                   ready_q;
   logic [BANK_ADDR_W-1:0] clr_idx_q;
   logic [DATA_W-1:0]      mem [NUM_BANKS][DEPTH];
   logic                   acc;
   logic [ADDR_W-1:0]      ea;
   logic [BANK_SEL_W-1:0]  ea_bank;
   logic [BANK_ADDR_W-1:0] ea_word;
   logic [NUM_BANKS-1:0]   bank_en;
   logic [ADDR_W-1:0]      ptr_q, ptr_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]      rd_data_q, rd_data_d;
   // Decode the request: effective address, one-hot bank enable, next pointer and read result
   always_comb begin
      acc        = bus.req_valid & ready_q;
      ea         = bus.req_incr ? ptr_q : bus.req_addr;
      ea_bank    = ea[ADDR_W-1:BANK_ADDR_W];
      ea_word    = ea[BANK_ADDR_W-1:0];
      bank_en    = '0;
      rd_valid_d = acc & ~bus.req_we;
      rd_data_d  = rd_data_q;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_en[b] = acc && (ea_bank == BANK_SEL_W'(b));
         if (bank_en[b] && !bus.req_we) rd_data_d = mem[b][ea_word];
      end
      // A load wins over the increment; the request itself still used the old pointer
      ptr_d = (ready_q & bus.ptr_load) ? bus.req_addr
            : (acc & bus.req_incr)     ? ptr_q + ADDR_W'(1)
            :                            ptr_q;
   end
   // Storage: clear engine zeroes one word per bank per cycle, otherwise only the enabled bank writes
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (state_q == CLEAR) mem[b][clr_idx_q] <= '0;
         else if (bank_en[b] && bus.req_we) mem[b][ea_word] <= bus.req_wdata;
      end
   end
   // Control FSM: sweep clr_idx through every word, then sit in READY until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         busy_q    <= (CLEAR_ON_RESET != 0);
         ready_q   <= 1'b0;
         clr_idx_q <= '0;
      end else if (state_q == CLEAR) begin
         clr_idx_q <= clr_idx_q + BANK_ADDR_W'(1);
         if (clr_idx_q == '1) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
         end
      end else begin
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end
   end
   // Datapath registers: pointer and registered read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end
   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.ptr       = ptr_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_ram_banked_stream.sv
// tb_ram_banked_stream: directed scoreboard bench for ram_banked_stream
module tb_ram_banked_stream;
   logic clk;
   logic rst;
   logic rst0;
   ram_banked_stream_if #(.DATA_W(8), .ADDR_W(4)) bus ();
   ram_banked_stream_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();
   ram_banked_stream #(.CLEAR_ON_RESET(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   ram_banked_stream #(.CLEAR_ON_RESET(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
   int passed = 0;
   int total = 0;
   logic [7:0] sbq[$];
   logic [7:0] model [16];
   logic [3:0] mptr;
   logic [7:0] exp_rd;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   // Scoreboard: a read accepted at a rising edge must show up at the following falling edge
   always @(negedge clk) begin
      chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, sbq.size() != 0});
      if (bus.rd_valid && sbq.size() != 0) begin
         exp_rd = sbq.pop_front();
         chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_rd});
      end
   end
   task automatic op(input logic v, input logic we, input logic incr, input logic pl,
                     input logic [3:0] a, input logic [7:0] d);
      logic [3:0] ea;
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_incr  = incr;
      bus.ptr_load  = pl;
      bus.req_addr  = a;
      bus.req_wdata = d;
      ea = incr ? mptr : a;
      @(posedge clk);
      if (v && !we) sbq.push_back(model[ea]);
      if (v && we) model[ea] = d;
      if (v && incr) mptr = mptr + 4'd1;
      if (pl) mptr = a;
      #1;
      bus.req_valid = 1'b0;
      bus.ptr_load  = 1'b0;
   endtask
   task automatic clear_count(input string tag);
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(bus.busy && !bus.req_ready)) break;
         n++;
      end
      chk(tag, n, 8);
      chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      mptr = 4'd0;
   endtask
   initial begin
      rst = 1'b1;
      rst0 = 1'b1;
      mptr = 4'd0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      {bus.req_valid, bus.req_we, bus.req_incr, bus.ptr_load} = 4'b0;
      bus.req_addr = 4'd0;
      bus.req_wdata = 8'd0;
      {bus0.req_valid, bus0.req_we, bus0.req_incr, bus0.ptr_load} = 4'b0;
      bus0.req_addr = 4'd0;
      bus0.req_wdata = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
      chk("rst_ptr", {28'd0, bus.ptr}, 32'd0);
      chk("rst0_ready", {31'd0, bus0.req_ready}, 32'd0);
      chk("rst0_busy", {31'd0, bus0.busy}, 32'd0);
      rst = 1'b0;
      clear_count("clear1");
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) op(1, 0, 0, 0, 4'(i), 8'h00);
      op(1, 1, 0, 0, 4'h3, 8'hA5);
      op(1, 1, 0, 0, 4'hB, 8'h5A);
      op(1, 0, 0, 0, 4'h3, 8'h00);
      op(1, 0, 0, 0, 4'hB, 8'h00);
      op(1, 1, 0, 0, 4'h2, 8'h3C);
      @(negedge clk);
      chk("wr_keeps_rd_data", {24'd0, bus.rd_data}, 32'h5A);
      op(0, 0, 0, 1, 4'h6, 8'h00);
      for (int i = 0; i < 4; i++) op(1, 1, 1, 0, 4'h0, 8'h10 + 8'(i));
      chk("burst_ptr", {28'd0, bus.ptr}, 32'hA);
      chk("burst_mem8", {24'd0, model[8]}, 32'h12);
      op(0, 0, 0, 1, 4'h6, 8'h00);
      for (int i = 0; i < 4; i++) op(1, 0, 1, 0, 4'h0, 8'h00);
      op(0, 0, 0, 1, 4'hF, 8'h00);
      op(1, 1, 1, 0, 4'h0, 8'h77);
      op(1, 1, 1, 0, 4'h0, 8'h88);
      chk("wrap_ptr", {28'd0, bus.ptr}, 32'h1);
      op(1, 0, 0, 0, 4'hF, 8'h00);
      op(1, 0, 0, 0, 4'h0, 8'h00);
      op(0, 0, 0, 1, 4'h2, 8'h00);
      op(1, 0, 1, 1, 4'h9, 8'h00);
      chk("collide_ptr", {28'd0, bus.ptr}, 32'h9);
      @(negedge clk);
      op(1, 0, 0, 0, 4'h3, 8'h00);
      rst = 1'b1;
      sbq.delete();
      #1;
      chk("midrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("midrst_rd_data", {24'd0, bus.rd_data}, 32'd0);
      chk("midrst_ptr", {28'd0, bus.ptr}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_count("clear2");
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) op(1, 0, 0, 0, 4'(i), 8'h00);
      op(1, 1, 0, 0, 4'h5, 8'hEE);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("clr3_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_count("clear3");
      @(posedge clk);
      #1;
      op(1, 0, 0, 0, 4'h5, 8'h00);
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      chk("noclr_ready_before", {31'd0, bus0.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("noclr_ready_after", {31'd0, bus0.req_ready}, 32'd1);
      chk("noclr_busy", {31'd0, bus0.busy}, 32'd0);
      @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
